// File: rtl/gshare_pkg.sv
// gshare_pkg: definitions shared by the branch predictor files.
//   - Default values for the predictor geometry parameters.
//   - pc_select_e: encoding of the PC mux select driven by the predictor.
package gshare_pkg;

    localparam int DEF_PHT_BITS = 4;  // PHT index width (2^PHT_BITS counters)
    localparam int DEF_CTR_BITS = 2;  // saturating counter width
    localparam int DEF_GHR_BITS = 4;  // global history length
    localparam int DEF_MODE     = 1;  // 0 = bimodal, 1 = gshare

    typedef enum logic [1:0] {
        PCSEL_SEQ    = 2'd0,  // IF PC + 4
        PCSEL_ID_TGT = 2'd1,  // predicted-taken target from ID
        PCSEL_EX_SEQ = 2'd2,  // recovery: EX PC + 4
        PCSEL_EX_TGT = 2'd3   // recovery: EX branch target
    } pc_select_e;

endpackage

// File: rtl/gshare_predictor_sat_counter.sv
// sat_counter: combinational next-value logic for one saturating counter.
//   value      in   WIDTH  current counter value
//   up         in   1      1 = increment, 0 = decrement
//   next_value out  WIDTH  updated value, clamped to [0, 2^WIDTH-1]
module sat_counter #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] value,
    input  logic             up,
    output logic [WIDTH-1:0] next_value
);

    always_comb begin
        next_value = value;
        if (up) begin
            if (value != '1) next_value = value + WIDTH'(1);
        end else begin
            if (value != '0) next_value = value - WIDTH'(1);
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: bimodal / gshare direction predictor with pipeline
// redirect control and resolved-branch statistics.
//   clk_i, rst_i      clock and synchronous active-high reset
//   ID_Branch_i       a branch is in ID
//   ID_pc_i           PC of the ID instruction
//   stall_i           IF/ID hazard stall (gates only the ID redirect)
//   EX_Branch_i       a branch is resolving in EX
//   EX_realTaken_i    resolved direction
//   EX_predTaken_i    prediction carried down the pipe with the branch
//   EX_index_i        PHT index carried down the pipe with the branch
//   ID_predTaken_o    prediction for the ID branch
//   ID_index_o        PHT index used for the ID lookup
//   flush_IF_ID_o     flush the IF/ID register
//   flush_ID_EX_o     flush the ID/EX register
//   pc_select_o       PC mux select (pc_select_e)
//   branch_cnt_o      resolved branches (saturating, registered)
//   mispred_cnt_o     mispredictions (saturating, registered)
module gshare_predictor
    import gshare_pkg::*;
#(
    parameter int PHT_BITS = DEF_PHT_BITS,
    parameter int CTR_BITS = DEF_CTR_BITS,
    parameter int GHR_BITS = DEF_GHR_BITS,
    parameter int MODE     = DEF_MODE
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ID_Branch_i,
    input  logic [31:0]         ID_pc_i,
    input  logic                stall_i,
    input  logic                EX_Branch_i,
    input  logic                EX_realTaken_i,
    input  logic                EX_predTaken_i,
    input  logic [PHT_BITS-1:0] EX_index_i,
    output logic                ID_predTaken_o,
    output logic [PHT_BITS-1:0] ID_index_o,
    output logic                flush_IF_ID_o,
    output logic                flush_ID_EX_o,
    output logic [1:0]          pc_select_o,
    output logic [31:0]         branch_cnt_o,
    output logic [31:0]         mispred_cnt_o
);

    localparam int PHT_ENTRIES = 1 << PHT_BITS;
    // Weakly taken: only the MSB set.
    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b1, {(CTR_BITS-1){1'b0}}};

    logic [CTR_BITS-1:0] pht [PHT_ENTRIES];
    logic [GHR_BITS-1:0] ghr;
    logic [GHR_BITS-1:0] ghr_next;
    logic [PHT_BITS-1:0] pc_bits;
    logic [PHT_BITS-1:0] id_index;
    logic [CTR_BITS-1:0] ex_ctr_next;
    logic [31:0]         branch_cnt;
    logic [31:0]         mispred_cnt;
    logic                mispredict;
    logic                id_pred;
    pc_select_e          pc_sel;
    logic                unused_pc_bits;

    // Word-aligned PC bits index the table; the rest of the PC is not used.
    assign pc_bits        = ID_pc_i[PHT_BITS+1:2];
    assign unused_pc_bits = ^{ID_pc_i[31:PHT_BITS+2], ID_pc_i[1:0]};

    generate
        if (MODE == 1) begin : g_gshare
            assign id_index = pc_bits ^ PHT_BITS'(ghr);
        end else begin : g_bimodal
            assign id_index = pc_bits;
        end

        if (GHR_BITS == 1) begin : g_ghr_one
            assign ghr_next = EX_realTaken_i;
        end else begin : g_ghr_shift
            assign ghr_next = {ghr[GHR_BITS-2:0], EX_realTaken_i};
        end
    endgenerate

    assign mispredict = EX_Branch_i && (EX_realTaken_i != EX_predTaken_i);

    // Read is of the registered table, so a same-cycle EX write to the
    // same entry is not visible until after the edge.
    assign id_pred = !rst_i && ID_Branch_i && pht[id_index][CTR_BITS-1];

    sat_counter #(
        .WIDTH(CTR_BITS)
    ) u_ctr (
        .value      (pht[EX_index_i]),
        .up         (EX_realTaken_i),
        .next_value (ex_ctr_next)
    );

    // EX recovery outranks the ID redirect; the stall only holds off the
    // ID redirect because the ID instruction is not advancing.
    always_comb begin
        pc_sel        = PCSEL_SEQ;
        flush_IF_ID_o = 1'b0;
        flush_ID_EX_o = 1'b0;
        if (!rst_i) begin
            if (mispredict) begin
                pc_sel        = EX_realTaken_i ? PCSEL_EX_TGT : PCSEL_EX_SEQ;
                flush_IF_ID_o = 1'b1;
                flush_ID_EX_o = 1'b1;
            end else if (id_pred && !stall_i) begin
                pc_sel        = PCSEL_ID_TGT;
                flush_IF_ID_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= CTR_INIT;
            end
            ghr         <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (EX_Branch_i) begin
                pht[EX_index_i] <= ex_ctr_next;
                ghr             <= ghr_next;
                if (branch_cnt != '1) branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispredict && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

    assign ID_predTaken_o = id_pred;
    assign ID_index_o     = id_index;
    assign pc_select_o    = pc_sel;
    assign branch_cnt_o   = branch_cnt;
    assign mispred_cnt_o  = mispred_cnt;

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: directed bench for gshare_predictor. A bimodal
// instance and a gshare instance share every input; each step drives the
// inputs, lets them settle and compares outputs with hand-computed values.
module tb_gshare_predictor;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        id_branch;
    logic [31:0] id_pc;
    logic        stall;
    logic        ex_branch;
    logic        ex_real;
    logic        ex_pred;
    logic [3:0]  ex_index;

    logic        b_pred, g_pred;
    logic [3:0]  b_index, g_index;
    logic        b_fif, g_fif, b_fex, g_fex;
    logic [1:0]  b_pcsel, g_pcsel;
    logic [31:0] b_branch, g_branch, b_mispred, g_mispred;

    gshare_predictor #(.PHT_BITS(4), .CTR_BITS(2), .GHR_BITS(4), .MODE(0)) u_bimodal (
        .clk_i(clk), .rst_i(rst), .ID_Branch_i(id_branch), .ID_pc_i(id_pc),
        .stall_i(stall), .EX_Branch_i(ex_branch), .EX_realTaken_i(ex_real),
        .EX_predTaken_i(ex_pred), .EX_index_i(ex_index),
        .ID_predTaken_o(b_pred), .ID_index_o(b_index), .flush_IF_ID_o(b_fif),
        .flush_ID_EX_o(b_fex), .pc_select_o(b_pcsel), .branch_cnt_o(b_branch),
        .mispred_cnt_o(b_mispred)
    );

    gshare_predictor #(.PHT_BITS(4), .CTR_BITS(2), .GHR_BITS(4), .MODE(1)) u_gshare (
        .clk_i(clk), .rst_i(rst), .ID_Branch_i(id_branch), .ID_pc_i(id_pc),
        .stall_i(stall), .EX_Branch_i(ex_branch), .EX_realTaken_i(ex_real),
        .EX_predTaken_i(ex_pred), .EX_index_i(ex_index),
        .ID_predTaken_o(g_pred), .ID_index_o(g_index), .flush_IF_ID_o(g_fif),
        .flush_ID_EX_o(g_fex), .pc_select_o(g_pcsel), .branch_cnt_o(g_branch),
        .mispred_cnt_o(g_mispred)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_branch;
    logic [31:0] exp_mispred;
    logic [9:0]  sat_real;
    logic [9:0]  sat_pred;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic settle;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic br, input logic [31:0] pc);
        id_branch = br;
        id_pc     = pc;
    endtask

    task automatic set_ex(input logic br, input logic real_t, input logic pred_t,
                          input logic [3:0] idx);
        ex_branch = br;
        ex_real   = real_t;
        ex_pred   = pred_t;
        ex_index  = idx;
    endtask

    // One resolved branch out of reset; expected counters track the inputs.
    task automatic ex_step(input logic real_t, input logic pred_t, input logic [3:0] idx);
        set_ex(1'b1, real_t, pred_t, idx);
        tick();
        exp_branch = exp_branch + 32'd1;
        if (real_t != pred_t) exp_mispred = exp_mispred + 32'd1;
        set_ex(1'b0, 1'b0, 1'b0, 4'd0);
        settle();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        set_id(1'b1, 32'h10);
        set_ex(1'b1, 1'b1, 1'b0, 4'd4);
        settle();
        // Outputs forced quiet while in reset, even with a mispredict pending.
        check("rst_pred", b_pred, 1'b0);
        check("rst_pcsel", b_pcsel, 2'd0);
        check("rst_flush_if", b_fif, 1'b0);
        check("rst_flush_ex", b_fex, 1'b0);

        tick();
        rst = 1'b0;
        set_ex(1'b0, 1'b0, 1'b0, 4'd0);
        exp_branch  = 32'd0;
        exp_mispred = 32'd0;
        settle();
        check("rst_branch_cnt", b_branch, exp_branch);
        check("rst_mispred_cnt", b_mispred, exp_mispred);

        // Bimodal lookup of a weakly taken entry redirects from ID.
        check("id_index", b_index, 4'd4);
        check("id_pred", b_pred, 1'b1);
        check("id_pcsel", b_pcsel, 2'd1);
        check("id_flush_if", b_fif, 1'b1);
        check("id_flush_ex", b_fex, 1'b0);

        // Mispredict predicted T, resolved NT at index 4.
        set_ex(1'b1, 1'b0, 1'b1, 4'd4);
        settle();
        check("mis_pcsel", b_pcsel, 2'd2);
        check("mis_flush_if", b_fif, 1'b1);
        check("mis_flush_ex", b_fex, 1'b1);
        check("mis_cnt_before_edge", b_mispred, 32'd0);
        tick();
        exp_branch  = exp_branch + 32'd1;
        exp_mispred = exp_mispred + 32'd1;
        set_ex(1'b0, 1'b0, 1'b0, 4'd0);
        settle();
        check("mis_pred_after", b_pred, 1'b0);
        check("mis_cnt_after", b_mispred, exp_mispred);
        check("mis_branch_after", b_branch, exp_branch);
        check("mis_pcsel_after", b_pcsel, 2'd0);

        // Saturation walk on index 4 starting from 1:
        // T,T,T,T -> 2,3,3,3 ; N,N,N,N -> 2,1,0,0 ; T,T -> 1,2
        sat_real = 10'b1100001111;
        sat_pred = 10'b1000011111;
        for (int i = 0; i < 10; i++) begin
            ex_step(sat_real[i], sat_real[i], 4'd4);
            check($sformatf("sat_pred_%0d", i), b_pred, sat_pred[i]);
            check($sformatf("sat_branch_%0d", i), b_branch, exp_branch);
        end
        check("sat_mispred", b_mispred, exp_mispred);

        // Same-cycle EX write and ID read at index 4 (counter currently 2).
        set_ex(1'b1, 1'b0, 1'b1, 4'd4);
        settle();
        check("pri_a_pred", b_pred, 1'b1);
        check("pri_a_pcsel", b_pcsel, 2'd2);
        tick();
        exp_branch  = exp_branch + 32'd1;
        exp_mispred = exp_mispred + 32'd1;
        set_ex(1'b1, 1'b1, 1'b0, 4'd4);
        settle();
        // Counter is 1 and being raised to 2: ID must still see 1.
        check("pri_b_no_bypass", b_pred, 1'b0);
        check("pri_b_pcsel", b_pcsel, 2'd3);
        check("pri_b_flush_if", b_fif, 1'b1);
        check("pri_b_flush_ex", b_fex, 1'b1);
        tick();
        exp_branch  = exp_branch + 32'd1;
        exp_mispred = exp_mispred + 32'd1;
        set_ex(1'b1, 1'b1, 1'b0, 4'd4);
        settle();
        // ID predicts taken, yet the EX recovery wins.
        check("pri_c_pred", b_pred, 1'b1);
        check("pri_c_pcsel", b_pcsel, 2'd3);
        tick();
        exp_branch  = exp_branch + 32'd1;
        exp_mispred = exp_mispred + 32'd1;
        set_ex(1'b0, 1'b0, 1'b0, 4'd0);
        settle();
        check("pri_branch_cnt", b_branch, exp_branch);
        check("pri_mispred_cnt", b_mispred, exp_mispred);

        // Stall holds off the ID redirect only.
        stall = 1'b1;
        settle();
        check("stall_pred", b_pred, 1'b1);
        check("stall_pcsel", b_pcsel, 2'd0);
        check("stall_flush_if", b_fif, 1'b0);
        check("stall_flush_ex", b_fex, 1'b0);
        stall = 1'b0;
        settle();
        check("unstall_pcsel", b_pcsel, 2'd1);

        // Reset mid-operation with a taken mispredict in EX: must be dropped.
        rst = 1'b1;
        set_ex(1'b1, 1'b1, 1'b0, 4'd4);
        settle();
        check("midrst_pcsel", b_pcsel, 2'd0);
        check("midrst_flush_if", b_fif, 1'b0);
        tick();
        rst = 1'b0;
        set_ex(1'b0, 1'b0, 1'b0, 4'd0);
        exp_branch  = 32'd0;
        exp_mispred = 32'd0;
        settle();
        check("midrst_branch_cnt", b_branch, exp_branch);
        check("midrst_mispred_cnt", b_mispred, exp_mispred);
        for (int i = 0; i < 16; i++) begin
            set_id(1'b1, 32'(i) << 2);
            settle();
            check($sformatf("midrst_entry_%0d", i), b_pred, 1'b1);
        end
        // Entry 4 must be exactly 2: one not-taken drops it below the MSB.
        set_id(1'b1, 32'h10);
        ex_step(1'b0, 1'b0, 4'd4);
        check("midrst_weak_entry", b_pred, 1'b0);
        check("midrst_branch_one", b_branch, exp_branch);

        // Gshare history: clean reset, then outcomes T,N,T,T -> GHR 1011.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_branch  = 32'd0;
        exp_mispred = 32'd0;
        set_id(1'b1, 32'h20);
        settle();
        check("gs_index_empty", g_index, 4'd8);
        ex_step(1'b1, 1'b1, 4'd0);
        ex_step(1'b0, 1'b0, 4'd0);
        ex_step(1'b1, 1'b1, 4'd0);
        ex_step(1'b1, 1'b1, 4'd0);
        check("gs_index_1011", g_index, 4'b0011);
        check("bm_index_pc20", b_index, 4'd8);
        check("gs_pred", g_pred, 1'b1);
        check("gs_pcsel", g_pcsel, 2'd1);
        check("gs_branch_cnt", g_branch, exp_branch);
        check("gs_mispred_cnt", g_mispred, exp_mispred);
        ex_step(1'b0, 1'b0, 4'd0);
        check("gs_index_0110", g_index, 4'b1110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
